// File: rtl/duel_sequencer.sv
// Round controller for the two-ship duel: arbitrates fire, times the shot,
// resolves hit/miss against armor and tracks scores to a declared winner.
module duel_sequencer #(
    parameter int SHOT_CYCLES     = 8,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int WIN_SCORE       = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       FIRE1,
    input  logic       FIRE2,
    input  logic [1:0] POS1,
    input  logic [1:0] POS2,
    input  logic       ARMOR1,
    input  logic       ARMOR2,
    output logic       SHOT_ACTIVE,
    output logic       SHOOTER,
    output logic       HIT,
    output logic       ARMOR_CLR1,
    output logic       ARMOR_CLR2,
    output logic [2:0] SCORE1,
    output logic [2:0] SCORE2,
    output logic       DONE,
    output logic [1:0] WINNER
);

    localparam int CNT_MAX = (SHOT_CYCLES > COOLDOWN_CYCLES) ?
                             SHOT_CYCLES : COOLDOWN_CYCLES;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE, ARMED, FLIGHT, RESOLVE, COOLDOWN, OVER
    } state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]  pos_q;
    logic        shooter_q;
    logic        last_q;
    logic        active_q;
    logic        hit_q;
    logic        clr1_q;
    logic        clr2_q;
    logic [2:0]  score1_q;
    logic [2:0]  score2_q;
    logic        done_q;
    logic [1:0]  winner_q;

    logic        fire_d;
    logic        grant_p2_d;
    logic [1:0]  opp_pos_d;
    logic        opp_armor_d;
    logic        hit_d;
    logic [2:0]  score_next_d;
    logic        win_d;

    always_comb begin
        fire_d       = FIRE1 | FIRE2;
        // On a tie the player not granted last wins the arbitration
        grant_p2_d   = (FIRE1 & FIRE2) ? ~last_q : FIRE2;
        opp_pos_d    = shooter_q ? POS1 : POS2;
        opp_armor_d  = shooter_q ? ARMOR1 : ARMOR2;
        hit_d        = (opp_pos_d == pos_q) && (pos_q != 2'b11);
        score_next_d = (shooter_q ? score2_q : score1_q) + 3'd1;
        win_d        = hit_d && !opp_armor_d &&
                       (score_next_d == 3'(WIN_SCORE));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pos_q     <= 2'b00;
            shooter_q <= 1'b0;
            last_q    <= 1'b1;
            active_q  <= 1'b0;
            hit_q     <= 1'b0;
            clr1_q    <= 1'b0;
            clr2_q    <= 1'b0;
            score1_q  <= 3'd0;
            score2_q  <= 3'd0;
            done_q    <= 1'b0;
            winner_q  <= 2'b00;
        end else begin
            hit_q  <= 1'b0;
            clr1_q <= 1'b0;
            clr2_q <= 1'b0;
            unique case (state_q)
                IDLE, OVER: begin
                    if (START) begin
                        score1_q <= 3'd0;
                        score2_q <= 3'd0;
                        done_q   <= 1'b0;
                        winner_q <= 2'b00;
                        state_q  <= ARMED;
                    end
                end
                ARMED: begin
                    if (fire_d) begin
                        shooter_q <= grant_p2_d;
                        last_q    <= grant_p2_d;
                        pos_q     <= grant_p2_d ? POS2 : POS1;
                        cnt_q     <= CW'(SHOT_CYCLES - 1);
                        active_q  <= 1'b1;
                        state_q   <= FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (cnt_q == '0) begin
                        active_q <= 1'b0;
                        state_q  <= RESOLVE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESOLVE: begin
                    if (hit_d) begin
                        hit_q <= 1'b1;
                        if (opp_armor_d) begin
                            clr1_q <= shooter_q;
                            clr2_q <= ~shooter_q;
                        end else if (shooter_q) begin
                            score2_q <= score_next_d;
                        end else begin
                            score1_q <= score_next_d;
                        end
                    end
                    if (win_d) begin
                        done_q   <= 1'b1;
                        winner_q <= shooter_q ? 2'b10 : 2'b01;
                        state_q  <= OVER;
                    end else begin
                        cnt_q   <= CW'(COOLDOWN_CYCLES - 1);
                        state_q <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (cnt_q == '0) begin
                        state_q <= ARMED;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SHOT_ACTIVE = active_q;
    assign SHOOTER     = shooter_q;
    assign HIT         = hit_q;
    assign ARMOR_CLR1  = clr1_q;
    assign ARMOR_CLR2  = clr2_q;
    assign SCORE1      = score1_q;
    assign SCORE2      = score2_q;
    assign DONE        = done_q;
    assign WINNER      = winner_q;

endmodule
